network: RTL and testbench

//  Parameterised fully-connected feed-forward network (MLP) inference engine in signed Q8.8.

---
 rtl/network_if.sv | 20 ++
 rtl/network.sv | 170 +++++++++++++++++
 tb/tb_network.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/network_if.sv
// Parameter-store / consumer bus of the MLP engine. Widths are in 16-bit words
// and must match the layer sizes the attached network instance is built with.
interface network_if #(
   parameter int NX = 2,   // input words
   parameter int NW = 9,   // weight words
   parameter int NB = 4,   // bias words
   parameter int NY = 1,   // output words
   parameter int NA = 6    // activation words (inputs plus every layer)
);
   logic                 start;
   logic [16*NX-1:0]     x;
   logic [16*NW-1:0]     w;
   logic [16*NB-1:0]     b;
   logic [16*NY-1:0]     y;
   logic [16*NA-1:0]     intermediate_states;
   logic                 done;

   modport master (output start, x, w, b, input y, intermediate_states, done);
   modport slave  (input start, x, w, b, output y, intermediate_states, done);
endinterface

// File: rtl/network.sv
// Q8.8 multilayer perceptron inference with one time-shared 16x16 MAC.
// Layers run in order; every layer's activations stay visible on intermediate_states.
module network #(
   parameter int                        MAX_LAYERS  = 8,
   parameter int                        NUM_LAYERS  = 2,
   parameter logic [16*(MAX_LAYERS+1)-1:0] LAYER_SIZES = {96'd0, 16'd1, 16'd3, 16'd2}
) (
   input  logic    clk,
   input  logic    rst_n,
   network_if.slave bus
);

   function automatic int sz(input int k);
      return int'(LAYER_SIZES[16*k +: 16]);
   endfunction

   function automatic int sum_w();
      int s = 0;
      for (int k = 0; k < NUM_LAYERS; k++) s += sz(k) * sz(k+1);
      return s;
   endfunction

   function automatic int sum_b();
      int s = 0;
      for (int k = 1; k <= NUM_LAYERS; k++) s += sz(k);
      return s;
   endfunction

   localparam int NX = sz(0);
   localparam int NY = sz(NUM_LAYERS);
   localparam int NW = sum_w();
   localparam int NB = sum_b();
   localparam int NA = NX + NB;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, WB, DONE} state_t;
   state_t state, state_nx;

   logic [16*NA-1:0]   acts;
   logic signed [39:0] acc;
   logic               done_r;
   logic [15:0]        layer, n, i, nin, nout;
   logic [31:0]        in_base, out_base, w_base, b_base;

   logic [31:0]        w_idx, a_idx, b_idx, o_idx;
   logic signed [15:0] wv, av, bv, res;
   logic signed [31:0] prod;
   logic signed [39:0] sh, v;
   logic [15:0]        next_size;
   logic               last_layer, last_in, last_n;

   assign last_layer = (layer == 16'(NUM_LAYERS - 1));
   assign last_in    = (i == nin - 16'd1);
   assign last_n     = (n == nout - 16'd1);

   // Column-major weights: weight(n, i) sits at layer base + i*Nout + n.
   assign w_idx = w_base + {16'd0, i} * {16'd0, nout} + {16'd0, n};
   assign a_idx = in_base + {16'd0, i};
   assign b_idx = b_base + {16'd0, n};
   assign o_idx = out_base + {16'd0, n};

   always_comb begin
      wv = '0;
      for (int j = 0; j < NW; j++)
         if (w_idx == 32'(j)) wv = bus.w[16*j +: 16];
      av = '0;
      for (int j = 0; j < NA; j++)
         if (a_idx == 32'(j)) av = acts[16*j +: 16];
      bv = '0;
      for (int j = 0; j < NB; j++)
         if (b_idx == 32'(j)) bv = bus.b[16*j +: 16];
      next_size = '0;
      for (int j = 0; j <= MAX_LAYERS; j++)
         if ({16'd0, layer} + 32'd2 == 32'(j)) next_size = LAYER_SIZES[16*j +: 16];
   end

   assign prod = wv * av;

   // Floor shift back to Q8.8, add bias, saturate, then ReLU on hidden layers.
   always_comb begin
      sh = acc >>> 8;
      v  = sh + {{24{bv[15]}}, bv};
      if (v > 40'sd32767)       res = 16'sh7fff;
      else if (v < -40'sd32768) res = 16'sh8000;
      else                      res = v[15:0];
      if (!last_layer && res[15]) res = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = LOAD;
         LOAD:    state_nx = MAC;
         MAC:     if (last_in) state_nx = WB;
         WB:      state_nx = (last_n && last_layer) ? DONE : MAC;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acts     <= '0;
         acc      <= '0;
         done_r   <= 1'b0;
         layer    <= '0;
         n        <= '0;
         i        <= '0;
         nin      <= '0;
         nout     <= '0;
         in_base  <= '0;
         out_base <= '0;
         w_base   <= '0;
         b_base   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               done_r            <= 1'b0;
               acts[16*NX-1:0]   <= bus.x;
            end
            LOAD: begin
               acc      <= '0;
               layer    <= '0;
               n        <= '0;
               i        <= '0;
               nin      <= 16'(NX);
               nout     <= 16'(sz(1));
               in_base  <= '0;
               out_base <= 32'(NX);
               w_base   <= '0;
               b_base   <= '0;
            end
            MAC: begin
               acc <= acc + {{8{prod[31]}}, prod};
               i   <= i + 16'd1;
            end
            WB: begin
               for (int j = 0; j < NA; j++)
                  if (o_idx == 32'(j)) acts[16*j +: 16] <= res;
               acc <= '0;
               i   <= '0;
               if (!last_n) begin
                  n <= n + 16'd1;
               end else begin
                  // Advance to the next layer: this layer's slot becomes its input.
                  n        <= '0;
                  layer    <= layer + 16'd1;
                  in_base  <= out_base;
                  out_base <= out_base + {16'd0, nout};
                  w_base   <= w_base + {16'd0, nin} * {16'd0, nout};
                  b_base   <= b_base + {16'd0, nout};
                  nin      <= nout;
                  nout     <= next_size;
               end
            end
            DONE:    done_r <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.done                = done_r;
   assign bus.intermediate_states = acts;
   assign bus.y                   = acts[16*NA-1 -: 16*NY];

endmodule

// File: tb/tb_network.sv
// Directed bench: a 2-3-1 network and a 1-1 network sharing clock and reset.
module tb_network;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   network_if #(.NX(2), .NW(9), .NB(4), .NY(1), .NA(6)) ifa ();
   network_if #(.NX(1), .NW(1), .NB(1), .NY(1), .NA(2)) ifb ();

   network #(.MAX_LAYERS(8), .NUM_LAYERS(2),
             .LAYER_SIZES({96'd0, 16'd1, 16'd3, 16'd2}))
      u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

   network #(.MAX_LAYERS(8), .NUM_LAYERS(1),
             .LAYER_SIZES({112'd0, 16'd1, 16'd1}))
      u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   // Pulse start, optionally re-pulse it at cycle poke, count cycles until done.
   task automatic run_a(input logic [15:0] x0, input logic [15:0] x1,
                        input int poke, output int cyc);
      @(negedge clk);
      ifa.x = {x1, x0};
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      cyc = 0;
      while (ifa.done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         if (poke != 0 && cyc == poke) begin
            ifa.start = 1'b1;
            ifa.x = 32'h0;
         end
         @(posedge clk); #1;
         ifa.start = 1'b0;
         cyc++;
      end
   endtask

   task automatic run_b(input logic [15:0] xv, input logic [15:0] wv,
                        input logic [15:0] bv, output int cyc);
      @(negedge clk);
      ifb.x = xv; ifb.w = wv; ifb.b = bv;
      ifb.start = 1'b1;
      @(posedge clk); #1;
      ifb.start = 1'b0;
      cyc = 0;
      while (ifb.done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (ifa.done !== 1'b0 || ifa.y !== 16'h0 || ifa.intermediate_states !== 96'h0) begin
         failures++;
         $display("FAIL reset_a: done=%b y=%h is=%h required 0", ifa.done, ifa.y, ifa.intermediate_states);
      end
      checks++;
      if (ifb.done !== 1'b0 || ifb.y !== 16'h0) begin
         failures++;
         $display("FAIL reset_b: done=%b y=%h required 0", ifb.done, ifb.y);
      end
   endtask

   task automatic test_basic();
      int cyc;
      logic [95:0] exp_is;
      run_a(16'd256, 16'd128, 0, cyc);
      checks++;
      if (cyc !== 15) begin
         failures++;
         $display("FAIL basic_latency: got %0d required 15", cyc);
      end
      checks++;
      if (ifa.y !== 16'd392) begin
         failures++;
         $display("FAIL basic_y: got %0d required 392", $signed(ifa.y));
      end
      exp_is = {16'd392, 16'd177, 16'd140, 16'd101, 16'd128, 16'd256};
      checks++;
      if (ifa.intermediate_states !== exp_is) begin
         failures++;
         $display("FAIL basic_states: got %h required %h", ifa.intermediate_states, exp_is);
      end
   endtask

   task automatic test_relu();
      int cyc;
      logic [95:0] exp_is;
      run_a(16'hff00, 16'hff00, 0, cyc);
      checks++;
      if (ifa.y !== 16'd51) begin
         failures++;
         $display("FAIL relu_y: got %0d required 51", $signed(ifa.y));
      end
      exp_is = {16'd51, 16'd0, 16'd0, 16'd0, 16'hff00, 16'hff00};
      checks++;
      if (ifa.intermediate_states !== exp_is) begin
         failures++;
         $display("FAIL relu_states: got %h required %h", ifa.intermediate_states, exp_is);
      end
   endtask

   task automatic test_saturate();
      int cyc;
      run_b(16'h7fff, 16'h7fff, 16'h7fff, cyc);
      checks++;
      if (cyc !== 4) begin
         failures++;
         $display("FAIL sat_latency: got %0d required 4", cyc);
      end
      checks++;
      if (ifb.y !== 16'h7fff) begin
         failures++;
         $display("FAIL sat_pos: got %h required 7fff", ifb.y);
      end
      run_b(16'h8001, 16'h7fff, 16'h8001, cyc);
      checks++;
      if (ifb.y !== 16'h8000) begin
         failures++;
         $display("FAIL sat_neg: got %h required 8000", ifb.y);
      end
      // Small linear case: 2.0 * -1.5 + 0.25 = -2.75 (0xfd40)
      run_b(16'h0200, 16'hfe80, 16'h0040, cyc);
      checks++;
      if (ifb.y !== 16'hfd40) begin
         failures++;
         $display("FAIL linear_neg: got %h required fd40", ifb.y);
      end
   endtask

   task automatic test_busy_start();
      int cyc;
      run_a(16'd256, 16'd128, 5, cyc);
      checks++;
      if (cyc !== 15) begin
         failures++;
         $display("FAIL busy_latency: got %0d required 15", cyc);
      end
      checks++;
      if (ifa.y !== 16'd392 || ifa.intermediate_states[47:32] !== 16'd101) begin
         failures++;
         $display("FAIL busy_result: y=%0d n0=%0d required 392 101", $signed(ifa.y),
                  $signed(ifa.intermediate_states[47:32]));
      end
   endtask

   task automatic test_abort();
      int cyc;
      @(negedge clk);
      ifa.x = {16'd128, 16'd256};
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ifa.done !== 1'b0 || ifa.intermediate_states !== 96'h0 || ifa.y !== 16'h0) begin
         failures++;
         $display("FAIL abort_clear: done=%b is=%h required 0", ifa.done, ifa.intermediate_states);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_a(16'd256, 16'd128, 0, cyc);
      checks++;
      if (ifa.y !== 16'd392 || cyc !== 15) begin
         failures++;
         $display("FAIL abort_rerun: y=%0d cyc=%0d required 392 15", $signed(ifa.y), cyc);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_a(16'd256, 16'd128, 0, cyc);
      checks++;
      if (ifa.done !== 1'b1 || ifa.y !== 16'd392) begin
         failures++;
         $display("FAIL b2b_first: done=%b y=%0d required 1 392", ifa.done, $signed(ifa.y));
      end
      @(negedge clk);
      ifa.x = {16'hff00, 16'hff00};
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      checks++;
      if (ifa.done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_drop: got %b required 0", ifa.done);
      end
      cyc = 0;
      while (ifa.done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (ifa.y !== 16'd51 || cyc !== 15) begin
         failures++;
         $display("FAIL b2b_second: y=%0d cyc=%0d required 51 15", $signed(ifa.y), cyc);
      end
   endtask

   initial begin
      ifa.start = 1'b0;
      ifa.x = '0;
      ifa.w = {16'd230, 16'd204, 16'd179,
               16'd153, 16'd128, 16'd102, 16'd76, 16'd51, 16'd25};
      ifa.b = {16'd51, 16'd25, 16'd25, 16'd25};
      ifb.start = 1'b0;
      ifb.x = '0;
      ifb.w = '0;
      ifb.b = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_relu();
      test_saturate();
      test_busy_start();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
